// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared widths, source identifiers and the FIFO entry layout
//                used by the writeback stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int XLEN_C  = 32;
    localparam int AW_C    = 5;
    localparam int NREGS_C = 32;

    // Producer identity, used to remember who won the last two-way tie.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } src_e;

    // One retiring result: destination register and value.
    typedef struct packed {
        logic [AW_C-1:0]   addr;
        logic [XLEN_C-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Small synchronous FIFO with registered full/empty flags.
//                Exposes its storage and a per-slot valid mask so the owner
//                can scan pending entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type ENTRY_T = wb_entry_t
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  ENTRY_T               i_entry,
    input  logic                 i_pop,
    output ENTRY_T               o_head,
    output logic                 o_full,
    output logic                 o_empty,
    output ENTRY_T [DEPTH-1:0]   o_mem,
    output logic   [DEPTH-1:0]   o_valid
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]          wr_ptr_q, wr_ptr_d;
    logic [PW:0]          rd_ptr_q, rd_ptr_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    ENTRY_T [DEPTH-1:0]   mem_q, mem_d;
    logic                 w_push;
    logic                 w_pop;
    logic [PW:0]          w_count;

    assign w_push  = i_push && !full_q;
    assign w_pop   = i_pop && !empty_q;
    assign w_count = wr_ptr_q - rd_ptr_q;

    // Next pointers, storage write and flags derived from the next pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, w_push};
        rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, w_pop};
        mem_d    = mem_q;
        if (w_push) begin
            mem_d[wr_ptr_q[PW-1:0]] = i_entry;
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[PW] != rd_ptr_d[PW]) &&
                  (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]);
    end

    // State register; reset empties the FIFO and drops its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            mem_q    <= mem_d;
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        logic [PW-1:0] w_off;
        assign w_off      = PW'(i) - rd_ptr_q[PW-1:0];
        assign o_valid[i] = ({1'b0, w_off} < w_count);
    end

    assign o_head  = mem_q[rd_ptr_q[PW-1:0]];
    assign o_full  = full_q;
    assign o_empty = empty_q;
    assign o_mem   = mem_q;

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_stage
//  Description : Collects results from the ALU and load unit through small
//                FIFOs, arbitrates round-robin onto the single register-file
//                write port and exports a pending-write busy mask.
//                Optional macro WB_BYPASS_EN adds same-cycle read forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = XLEN_C,
    parameter int AW    = AW_C
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iAluValid,
    output logic               oAluReady,
    input  logic [AW-1:0]      iAluAddr,
    input  logic [XLEN-1:0]    iAluData,
    input  logic               iLdValid,
    output logic               oLdReady,
    input  logic [AW-1:0]      iLdAddr,
    input  logic [XLEN-1:0]    iLdData,
    output logic               oWrite,
    output logic [AW-1:0]      oAddrC,
    output logic [XLEN-1:0]    oRegC,
`ifdef WB_BYPASS_EN
    input  logic [AW-1:0]      iAddrA,
    input  logic [AW-1:0]      iAddrB,
    input  logic [XLEN-1:0]    iRegA,
    input  logic [XLEN-1:0]    iRegB,
    output logic [XLEN-1:0]    oRegA,
    output logic [XLEN-1:0]    oRegB,
`endif
    output logic [NREGS_C-1:0] oBusy
);

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t               alu_head, ld_head, head;
    entry_t [DEPTH-1:0]   alu_mem, ld_mem;
    logic   [DEPTH-1:0]   alu_valid_mask, ld_valid_mask;
    logic                 alu_full, alu_empty, ld_full, ld_empty;
    logic                 pop_alu, pop_ld;
    src_e                 last_q, last_d;
    logic                 write_q, write_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [XLEN-1:0]      data_q, data_d;
    logic [NREGS_C-1:0]   busy;

    wb_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_alu_fifo (
        .clk     (iClk),
        .rst     (iRst),
        .i_push  (iAluValid),
        .i_entry ('{addr: iAluAddr, data: iAluData}),
        .i_pop   (pop_alu),
        .o_head  (alu_head),
        .o_full  (alu_full),
        .o_empty (alu_empty),
        .o_mem   (alu_mem),
        .o_valid (alu_valid_mask)
    );

    wb_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_ld_fifo (
        .clk     (iClk),
        .rst     (iRst),
        .i_push  (iLdValid),
        .i_entry ('{addr: iLdAddr, data: iLdData}),
        .i_pop   (pop_ld),
        .o_head  (ld_head),
        .o_full  (ld_full),
        .o_empty (ld_empty),
        .o_mem   (ld_mem),
        .o_valid (ld_valid_mask)
    );

    // Ready depends only on the registered full flag, never on valid.
    assign oAluReady = !alu_full;
    assign oLdReady  = !ld_full;

    // Round-robin pick; the tie pointer moves only when both sources compete.
    always_comb begin
        pop_alu = 1'b0;
        pop_ld  = 1'b0;
        last_d  = last_q;
        if (!alu_empty && !ld_empty) begin
            if (last_q == SRC_ALU) begin
                pop_ld = 1'b1;
                last_d = SRC_LD;
            end else begin
                pop_alu = 1'b1;
                last_d  = SRC_ALU;
            end
        end else if (!alu_empty) begin
            pop_alu = 1'b1;
        end else if (!ld_empty) begin
            pop_ld = 1'b1;
        end
        head    = pop_ld ? ld_head : alu_head;
        write_d = (pop_alu || pop_ld) && (head.addr != '0);
        addr_d  = addr_q;
        data_d  = data_q;
        if (pop_alu || pop_ld) begin
            addr_d = head.addr;
            data_d = head.data;
        end
    end

    // Output registers and tie pointer; reset lets the ALU win the first tie.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            last_q  <= SRC_LD;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            last_q  <= last_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Pending-write mask over live FIFO slots plus the write in progress.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_valid_mask[i] && (alu_mem[i].addr != '0)) begin
                busy[alu_mem[i].addr] = 1'b1;
            end
            if (ld_valid_mask[i] && (ld_mem[i].addr != '0)) begin
                busy[ld_mem[i].addr] = 1'b1;
            end
        end
        if (write_q) begin
            busy[addr_q] = 1'b1;
        end
        busy[0] = 1'b0;
    end

    assign oBusy  = busy;
    assign oWrite = write_q;
    assign oAddrC = addr_q;
    assign oRegC  = data_q;

`ifdef WB_BYPASS_EN
    // Forward the write in progress to matching read ports in the same cycle.
    always_comb begin
        oRegA = iRegA;
        oRegB = iRegB;
        if (write_q && (addr_q == iAddrA) && (iAddrA != '0)) begin
            oRegA = data_q;
        end
        if (write_q && (addr_q == iAddrB) && (iAddrB != '0)) begin
            oRegB = data_q;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_stage
//  Description : Self-checking bench for writeback_stage using a queue-based
//                reference model, directed scenarios and random traffic.
//                Honours WB_BYPASS_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    localparam int DEPTH = 2;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, ld_valid = 1'b0;
    logic [4:0]  alu_addr = '0, ld_addr = '0;
    logic [31:0] alu_data = '0, ld_data = '0;
    logic        alu_ready, ld_ready, wr;
    logic [4:0]  addr_c;
    logic [31:0] reg_c, busy;
`ifdef WB_BYPASS_EN
    logic [4:0]  addr_a = '0, addr_b = '0;
    logic [31:0] reg_a_in = '0, reg_b_in = '0, reg_a_out, reg_b_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Producer scripts (not yet accepted) and model FIFO contents.
    ent_t a_scr[$], l_scr[$], a_q[$], l_q[$];
    bit          m_last_alu;
    logic        m_write;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    writeback_stage #(.DEPTH(DEPTH), .XLEN(32), .AW(5)) dut (
        .iClk      (clk),
        .iRst      (rst),
        .iAluValid (alu_valid),
        .oAluReady (alu_ready),
        .iAluAddr  (alu_addr),
        .iAluData  (alu_data),
        .iLdValid  (ld_valid),
        .oLdReady  (ld_ready),
        .iLdAddr   (ld_addr),
        .iLdData   (ld_data),
        .oWrite    (wr),
        .oAddrC    (addr_c),
        .oRegC     (reg_c),
`ifdef WB_BYPASS_EN
        .iAddrA    (addr_a),
        .iAddrB    (addr_b),
        .iRegA     (reg_a_in),
        .iRegB     (reg_b_in),
        .oRegA     (reg_a_out),
        .oRegB     (reg_b_out),
`endif
        .oBusy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Producers present the head of their script and hold it until accepted.
    task automatic drive();
        alu_valid = (a_scr.size() > 0);
        ld_valid  = (l_scr.size() > 0);
        if (alu_valid) begin
            alu_addr = a_scr[0].addr;
            alu_data = a_scr[0].data;
        end
        if (ld_valid) begin
            ld_addr = l_scr[0].addr;
            ld_data = l_scr[0].data;
        end
    endtask

    // Reference behaviour of one clock edge.
    task automatic model_update();
        bit   ra, rl, pa, pl;
        ent_t e;
        if (rst) begin
            a_q.delete();
            l_q.delete();
            m_write    = 1'b0;
            m_addr     = '0;
            m_data     = '0;
            m_last_alu = 1'b0;
            return;
        end
        ra = (a_q.size() < DEPTH);
        rl = (l_q.size() < DEPTH);
        pa = 1'b0;
        pl = 1'b0;
        if (a_q.size() > 0 && l_q.size() > 0) begin
            if (m_last_alu) pl = 1'b1;
            else            pa = 1'b1;
            m_last_alu = pa;
        end else if (a_q.size() > 0) begin
            pa = 1'b1;
        end else if (l_q.size() > 0) begin
            pl = 1'b1;
        end
        if (pa || pl) begin
            e       = pa ? a_q.pop_front() : l_q.pop_front();
            m_write = (e.addr != 0);
            m_addr  = e.addr;
            m_data  = e.data;
        end else begin
            m_write = 1'b0;
        end
        if (alu_valid && ra) a_q.push_back(a_scr.pop_front());
        if (ld_valid && rl)  l_q.push_back(l_scr.pop_front());
    endtask

    task automatic compare();
        logic [31:0] eb;
        eb = '0;
        foreach (a_q[i]) if (a_q[i].addr != 0) eb[a_q[i].addr] = 1'b1;
        foreach (l_q[i]) if (l_q[i].addr != 0) eb[l_q[i].addr] = 1'b1;
        if (m_write) eb[m_addr] = 1'b1;
        chk("alu_ready", {31'b0, alu_ready}, {31'b0, a_q.size() < DEPTH});
        chk("ld_ready",  {31'b0, ld_ready},  {31'b0, l_q.size() < DEPTH});
        chk("write",     {31'b0, wr},        {31'b0, m_write});
        chk("addr_c",    {27'b0, addr_c},    {27'b0, m_addr});
        chk("reg_c",     reg_c,              m_data);
        chk("busy",      busy,               eb);
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    initial begin
        logic [4:0] exp_seq [6];
        ent_t       e;

        // Reset while the ALU keeps offering {3, DEADBEEF}.
        for (int i = 0; i < 4; i++) a_scr.push_back('{5'd3, 32'hDEADBEEF});
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_write", {31'b0, wr}, 32'd0);
        end
        chk("rst_regc", reg_c, 32'd0);
        rst = 1'b0;
        step();
        chk("first_push_write", {31'b0, wr}, 32'd0);
        chk("first_push_busy", busy, 32'h0000_0008);
        step();
        chk("first_write", {31'b0, wr}, 32'd1);
        chk("first_addr", {27'b0, addr_c}, 32'd3);
        chk("first_data", reg_c, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) step();
        chk("drain_busy", busy, 32'd0);

        // Single ALU push {5, 12345678}.
        a_scr.push_back('{5'd5, 32'h12345678});
        step();
        chk("single_busy_n", busy, 32'h0000_0020);
        chk("single_write_n", {31'b0, wr}, 32'd0);
        step();
        chk("single_write", {31'b0, wr}, 32'd1);
        chk("single_addr", {27'b0, addr_c}, 32'd5);
        chk("single_data", reg_c, 32'h12345678);
        chk("single_busy_w", busy, 32'h0000_0020);
        step();
        chk("single_done", {31'b0, wr}, 32'd0);
        chk("single_clear", busy, 32'd0);

        // Both sources streaming: writes must alternate starting with the ALU.
        for (int i = 0; i < 3; i++) begin
            a_scr.push_back('{5'(1 + i), 32'hA000_0000 + i});
            l_scr.push_back('{5'(9 + i), 32'hB000_0000 + i});
        end
        exp_seq = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_write", {31'b0, wr}, 32'd1);
            chk("rr_addr", {27'b0, addr_c}, {27'b0, exp_seq[i]});
            if (i == 0) chk("ld_full", {31'b0, ld_ready}, 32'd0);
            if (i == 1) chk("ld_reopen", {31'b0, ld_ready}, 32'd1);
        end
        step();
        chk("rr_idle", {31'b0, wr}, 32'd0);

        // Address 0 is consumed silently.
        a_scr.push_back('{5'd0, 32'hFFFFFFFF});
        step();
        chk("zero_busy_n", busy, 32'd0);
        step();
        chk("zero_write", {31'b0, wr}, 32'd0);
        chk("zero_data", reg_c, 32'hFFFFFFFF);
        chk("zero_busy", busy, 32'd0);
        step();

`ifdef WB_BYPASS_EN
        // Forwarding of the write in progress.
        a_scr.push_back('{5'd7, 32'hA5A5A5A5});
        step();
        step();
        addr_a = 5'd7; reg_a_in = 32'd0;
        addr_b = 5'd6; reg_b_in = 32'h1111_2222;
        #1;
        chk("byp_a_hit", reg_a_out, 32'hA5A5A5A5);
        chk("byp_b_miss", reg_b_out, 32'h1111_2222);
        addr_a = 5'd0; reg_a_in = 32'h0000_0012;
        #1;
        chk("byp_a_zero", reg_a_out, 32'h0000_0012);
        step();
`endif

        // Random traffic with one mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            if (a_scr.size() < 2 && $urandom_range(0, 99) < 70) begin
                e.addr = 5'($urandom_range(0, 7));
                e.data = $urandom;
                a_scr.push_back(e);
            end
            if (l_scr.size() < 2 && $urandom_range(0, 99) < 60) begin
                e.addr = 5'($urandom_range(0, 12));
                e.data = $urandom;
                l_scr.push_back(e);
            end
            rst = (c >= 1500 && c < 1502);
            step();
        end
        rst = 1'b0;
        a_scr.delete();
        l_scr.delete();
        for (int i = 0; i < 8; i++) step();
        chk("final_busy", busy, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Writeback stage directly upstream of the 32x32 register file.
- Accepts retiring results from two producers, the ALU and the load unit, over valid/ready channels, each with a small FIFO.
- Arbitrates round-robin and drives the register file's single write port (write enable, address C, data C), one write per cycle.
- Exports a pending-write busy mask that upstream hazard logic uses to stall.

Parameters:
- DEPTH, 2, entries per source FIFO; power of two, >= 2.
- XLEN, 32, data width.
- AW, 5, register address width.

Ports:
- iClk  in  1  clock; all state updates on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iAluValid  in  1  ALU result valid.
- oAluReady  out  1  ALU FIFO not full.
- iAluAddr  in  AW  ALU destination register.
- iAluData  in  XLEN  ALU result.
- iLdValid  in  1  load result valid.
- oLdReady  out  1  load FIFO not full.
- iLdAddr  in  AW  load destination register.
- iLdData  in  XLEN  load data.
- oWrite  out  1  register file write enable.
- oAddrC  out  AW  register file write address.
- oRegC  out  XLEN  register file write data.
- oBusy  out  32  bit k set while a write to rk is pending in either FIFO or on the output registers; bit 0 is always 0.

Behaviour:
- Reset (synchronous, iRst=1 at edge): both FIFOs empty; oWrite=0, oAddrC=0, oRegC=0; round-robin pointer set so the ALU wins the first tie.
  - Entries in flight when reset asserts are discarded, with no register file write.
  - Ready outputs are 1 the cycle after reset deasserts.
- Handshake:
  - A transfer happens at an edge where valid && ready.
  - oXReady = !full, computed from registered state only; no combinational valid-to-ready path.
  - Full FIFO with a pop in the same cycle: ready stays 0 that cycle; no pass-through.
  - Valid held with ready low: the producer holds address and data stable; the block does not sample them.
- Pop and arbitration, each edge:
  - If exactly one FIFO is non-empty, pop its head.
  - If both are non-empty, pop the source not granted last; the pointer updates only on a two-way tie.
  - A popped entry loads oAddrC/oRegC, and oWrite=1 for the following cycle.
  - No pop: oWrite=0; oAddrC and oRegC hold their last values.
- Latency:
  - Push at edge N gives earliest oWrite=1 in the cycle after edge N+1.
  - The register file commits at edge N+2.
  - A newly pushed entry is not poppable at the same edge it is pushed.
- Sustained throughput: one write per cycle total. Each source gets at least every other slot under contention.
- Address 0:
  - Entries with address 0 are accepted and popped normally, but produce oWrite=0.
  - They contribute nothing to oBusy.
- oBusy:
  - Combinational OR over all valid FIFO entries plus the output register when oWrite=1.
  - It clears the cycle after the final write commits.
- Ordering:
  - Per-source FIFO order is preserved.
  - No ordering is guaranteed between sources. Upstream must not issue two in-flight writes to the same register from different sources; the stage does not check this.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Full/empty use an extra wrap bit.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: adds ports iAddrA, iAddrB (AW), iRegA, iRegB (XLEN, from the register file), and oRegA, oRegB (XLEN).
  - oRegA = oRegC when oWrite && oAddrC==iAddrA && iAddrA!=0; otherwise oRegA = iRegA. oRegB follows the same rule with B.
  - This path is combinational and gives same-cycle read-after-write forwarding.
- Undefined: these ports are absent; readers see the register file value, which updates one edge after oWrite.

Decomposition:
- Package wb_pkg holds:
  - XLEN_C=32, AW_C=5, NREGS_C=32;
  - enum src_e {SRC_ALU, SRC_LD};
  - struct wb_entry_t {addr, data}.
- Sub-module wb_fifo (parameterised DEPTH, entry type, registered full/empty) is instantiated once per source.
- Arbitration, output registers and busy mask live in the top module.

Test Plan:
- Reset with the ALU pushing {addr 3, data 0xDEADBEEF} every cycle -> no oWrite while iRst=1; first write appears 2 cycles after the first accepted push.
- Single ALU push {5, 0x12345678} at edge N -> oWrite=1, oAddrC=5, oRegC=0x12345678 for exactly one cycle after edge N+1. oBusy[5]=1 from after edge N until the cycle after the commit.
- Both sources push every cycle (ALU addrs 1,2,3; load addrs 9,10,11) -> writes alternate ALU,LD,ALU,LD,ALU,LD, starting with ALU, with no gaps.
- Load consumer stalled so the load FIFO fills (DEPTH=2) -> oLdReady=0 after 2 accepts; a held third valid is not taken until the cycle after a pop; no data is lost or duplicated.
- Push to addr 0 with data 0xFFFFFFFF -> entry consumed; oWrite stays 0; oBusy stays 0.
- With WB_BYPASS_EN: oWrite writing addr 7 = 0xA5A5A5A5 while iAddrA=7, iRegA=0 -> oRegA=0xA5A5A5A5. With iAddrA=0 -> oRegA=iRegA.
